// File: rtl/ahbl_slave_mem.sv
// ahbl_slave_mem: AHB-Lite slave RAM with optional wait states and two-cycle ERROR responses.
// Optional feature macro: AHBL_SLAVE_MEM_WAIT_EN builds the WAIT state and 4-bit wait counter;
// without it every OKAY data phase is zero-wait regardless of WAIT_STATES.
module ahbl_slave_mem #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t state, state_n;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] widx;
    logic [3:0] be, be_in;
    logic wr, dp, take, err_in;
    logic unused;
`ifdef AHBL_SLAVE_MEM_WAIT_EN
    logic [3:0] cnt, cnt_n;
    localparam state_t OK_ST = WAIT_STATES > 0 ? WAIT : IDLE;
`else
    localparam state_t OK_ST = IDLE;
`endif
    assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], 4'(WAIT_STATES)};
    // A transfer is only taken while this slave is not stalling its own data phase
    assign take = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign err_in = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'd0)
                    || {2'b00, HADDR[31:2]} >= 32'(DEPTH);
    assign be_in = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign HRDATA = dp && !wr && HREADYOUT ? mem[widx] : '0;

    // Next state: accept from IDLE/ERR2, count down wait cycles, walk the two error cycles
    always_comb begin
        state_n = state;
`ifdef AHBL_SLAVE_MEM_WAIT_EN
        cnt_n = cnt;
`endif
        case (state)
            ERR1: state_n = ERR2;
`ifdef AHBL_SLAVE_MEM_WAIT_EN
            WAIT: begin
                cnt_n = cnt - 4'd1;
                state_n = cnt == 4'd0 ? IDLE : WAIT;
            end
`endif
            default: begin
                state_n = !take ? IDLE : err_in ? ERR1 : OK_ST;
`ifdef AHBL_SLAVE_MEM_WAIT_EN
                cnt_n = 4'(WAIT_STATES - 1);
`endif
            end
        endcase
    end

    // State register with registered handshake outputs decoded from the next state
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP <= 1'b0;
        end else begin
            state <= state_n;
            HREADYOUT <= state_n != WAIT && state_n != ERR1;
            HRESP <= state_n == ERR1 || state_n == ERR2;
        end
    end

`ifdef AHBL_SLAVE_MEM_WAIT_EN
    // Wait-cycle counter
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN)
            cnt <= 4'd0;
        else
            cnt <= cnt_n;
    end
`endif

    // Capture the address phase whenever the bus can advance; dp marks a pending OKAY data phase
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp <= 1'b0;
            wr <= 1'b0;
            widx <= '0;
            be <= 4'd0;
        end else if (HREADYOUT) begin
            dp <= take && !err_in;
            wr <= HWRITE;
            widx <= HADDR[AW+1:2];
            be <= be_in;
        end
    end

    // Commit the addressed byte lanes at the end of the completing write data-phase cycle
    always_ff @(posedge HCLK) begin
        if (dp && wr && HREADYOUT)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule

// File: tb/tb_ahbl_slave_mem.sv
// tb_ahbl_slave_mem: directed AHB-Lite traffic checked cycle by cycle against a transaction-level model.
module tb_ahbl_slave_mem;
    localparam int DEPTH = 64;
    localparam int WS = 3;
`ifdef AHBL_SLAVE_MEM_WAIT_EN
    localparam int EWS = WS;
`else
    localparam int EWS = 0;
`endif
    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0] htrans = 2'd0;
    logic hwrite = 1'b0;
    logic [2:0] hsize = 3'd0;
    logic [31:0] hwdata = '0;
    logic hreadyout, hresp;
    logic [31:0] hrdata;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int low_cnt = 0;
    exp_t exp_q[$];
    exp_t ec;
    item_t sq[$];
    logic [7:0] mb [DEPTH*4];

    always #5 clk = ~clk;

    ahbl_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd1), .HPROT(4'd3), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(hreadyout), .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
    );

    // Compare every cycle's outputs with the model's expectation for that cycle
    always @(negedge clk) begin
        cyc++;
        if (!hreadyout) low_cnt++;
        if (exp_q.size() > 0) begin
            ec = exp_q.pop_front();
            vectors++;
            if (hreadyout !== ec.rdy || hresp !== ec.resp || hrdata !== ec.rdata) begin
                miscompares++;
                $display("FAIL cycle%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                         cyc, hreadyout, hresp, hrdata, ec.rdy, ec.resp, ec.rdata);
            end
        end
    end

    function automatic exp_t mk(logic rdy, logic resp, logic [31:0] rdata);
        exp_t e;
        e.rdy = rdy;
        e.resp = resp;
        e.rdata = rdata;
        return e;
    endfunction

    function automatic item_t it(logic sel, logic [1:0] trans, logic wr, logic [2:0] size, logic [31:0] addr, logic [31:0] data);
        item_t t;
        t.sel = sel;
        t.trans = trans;
        t.wr = wr;
        t.size = size;
        t.addr = addr;
        t.data = data;
        return t;
    endfunction

    function automatic bit is_err(item_t t);
        return t.size > 3'd2 || (t.size == 3'd1 && t.addr % 2 != 0) || (t.size == 3'd2 && t.addr % 4 != 0)
               || t.addr / 4 >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int w;
        w = int'(a / 4);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    function automatic void model_write(item_t t);
        int lane;
        lane = int'(t.addr % 4);
        for (int b = 0; b < (1 << t.size); b++)
            mb[int'(t.addr) + b] = t.data[8*(lane + b) +: 8];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive(item_t a, logic [31:0] wdata, exp_t e);
        @(posedge clk);
        #1;
        hsel = a.sel;
        htrans = a.trans;
        hwrite = a.wr;
        hsize = a.size;
        haddr = a.addr;
        hwdata = wdata;
        exp_q.push_back(e);
    endtask

    // One data phase of cur while nxt's address phase sits on the bus
    task automatic data_phase(item_t cur, item_t nxt);
        logic [31:0] rd;
        if (!(cur.sel && cur.trans[1])) begin
            drive(nxt, cur.data, mk(1'b1, 1'b0, 32'h0));
        end else if (is_err(cur)) begin
            drive(nxt, cur.data, mk(1'b0, 1'b1, 32'h0));
            drive(nxt, cur.data, mk(1'b1, 1'b1, 32'h0));
        end else begin
            if (cur.wr) model_write(cur);
            rd = cur.wr ? 32'h0 : model_word(cur.addr);
            repeat (EWS) drive(nxt, cur.data, mk(1'b0, 1'b0, 32'h0));
            drive(nxt, cur.data, mk(1'b1, 1'b0, rd));
        end
    endtask

    task automatic run();
        item_t cur, nxt, idle_it;
        idle_it = it(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0);
        cur = idle_it;
        for (int i = 0; i <= sq.size(); i++) begin
            nxt = i < sq.size() ? sq[i] : idle_it;
            data_phase(cur, nxt);
            cur = nxt;
        end
        sq.delete();
    endtask

    task automatic wr_w(logic [31:0] a, logic [2:0] s, logic [31:0] d);
        sq.push_back(it(1'b1, 2'd2, 1'b1, s, a, d));
    endtask

    task automatic rd_w(logic [31:0] a, logic [2:0] s);
        sq.push_back(it(1'b1, 2'd2, 1'b0, s, a, 32'h0));
    endtask

    initial begin
        // Reset state held for two cycles, released mid-cycle
        repeat (2) drive(it(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0), 32'h0, mk(1'b1, 1'b0, 32'h0));
        #2 rst_n = 1'b1;

        // Back-to-back write then read of the same word
        wr_w(32'h00, 3'd2, 32'hCAFEF00D);
        wr_w(32'h40, 3'd2, 32'h12345678);
        run();
        low_cnt = 0;
        wr_w(32'h10, 3'd2, 32'hDEADBEEF);
        rd_w(32'h10, 3'd2);
        run();
        chk("b2b_low_cycles", 32'(low_cnt), 32'(2 * EWS));
        chk("pin_deadbeef", model_word(32'h10), 32'hDEADBEEF);

        // Byte and halfword lane writes
        wr_w(32'h10, 3'd2, 32'h11223344);
        wr_w(32'h13, 3'd0, 32'hAA000000);
        rd_w(32'h10, 3'd2);
        wr_w(32'h14, 3'd2, 32'h00000000);
        wr_w(32'h16, 3'd1, 32'hBEEF0000);
        wr_w(32'h19, 3'd0, 32'h00005A00);
        rd_w(32'h14, 3'd1);
        run();
        chk("pin_byte_lane", model_word(32'h10), 32'hAA223344);
        chk("pin_half_lane", model_word(32'h14), 32'hBEEF0000);

        // Single read with idle around it: low exactly EWS cycles
        low_cnt = 0;
        rd_w(32'h10, 3'd2);
        run();
        chk("wait_cycles", 32'(low_cnt), 32'(EWS));

        // Errors: misaligned word, out-of-range, misaligned half, oversized, high address
        low_cnt = 0;
        wr_w(32'h02, 3'd2, 32'h0BADF00D);
        rd_w(32'(DEPTH * 4), 3'd2);
        wr_w(32'h01, 3'd1, 32'hFFFFFFFF);
        wr_w(32'h00, 3'd3, 32'hFFFFFFFF);
        wr_w(32'h8000_0000, 3'd2, 32'hFFFFFFFF);
        run();
        chk("err_low_cycles", 32'(low_cnt), 32'd5);
        rd_w(32'h00, 3'd2);
        run();
        chk("pin_err_untouched", model_word(32'h00), 32'hCAFEF00D);

        // Burst with BUSY/IDLE interleaved, plus an unselected write
        wr_w(32'h30, 3'd2, 32'h30303030);
        wr_w(32'h20, 3'd2, 32'hA0A0A0A0);
        sq.push_back(it(1'b1, 2'd1, 1'b1, 3'd2, 32'h24, 32'h0));
        sq.push_back(it(1'b1, 2'd3, 1'b1, 3'd2, 32'h24, 32'hB1B1B1B1));
        sq.push_back(it(1'b1, 2'd1, 1'b1, 3'd2, 32'h28, 32'h0));
        sq.push_back(it(1'b1, 2'd3, 1'b1, 3'd2, 32'h28, 32'hC2C2C2C2));
        sq.push_back(it(1'b1, 2'd1, 1'b1, 3'd2, 32'h2C, 32'h0));
        sq.push_back(it(1'b1, 2'd3, 1'b1, 3'd2, 32'h2C, 32'hD3D3D3D3));
        sq.push_back(it(1'b1, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0));
        sq.push_back(it(1'b0, 2'd2, 1'b1, 3'd2, 32'h30, 32'hEEEEEEEE));
        for (int a = 32'h20; a <= 32'h30; a += 4) rd_w(32'(a), 3'd2);
        run();
        chk("pin_burst_last", model_word(32'h2C), 32'hD3D3D3D3);
        chk("pin_unselected", model_word(32'h30), 32'h30303030);

        // Reset asserted during the data phase of a write to 0x40
        drive(it(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h0), 32'h0, mk(1'b1, 1'b0, 32'h0));
        drive(it(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0), 32'h5555AAAA, mk(1'b1, 1'b0, 32'h0));
        #1 rst_n = 1'b0;
        drive(it(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0), 32'h5555AAAA, mk(1'b1, 1'b0, 32'h0));
        #2 rst_n = 1'b1;
        rd_w(32'h40, 3'd2);
        wr_w(32'h40, 3'd2, 32'h600DD00D);
        rd_w(32'h40, 3'd2);
        run();
        chk("pin_after_reset", model_word(32'h40), 32'h600DD00D);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
